// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants and types for the LED pattern generator
package led_pkg;

    // Pattern selection codes carried on iMODE
    localparam logic [1:0] MODE_ROT_L = 2'd0;
    localparam logic [1:0] MODE_ROT_R = 2'd1;
    localparam logic [1:0] MODE_PING  = 2'd2;
    localparam logic [1:0] MODE_BLINK = 2'd3;

    // Width of the speed select; the step period is TICK_DIV >> iSPEED
    localparam int SPEED_W = 2;

    // Ping-pong travel direction of the lit LED
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/led_tick_prescaler.sv
// rtl/led_tick_prescaler.sv - programmable step prescaler with registered tick pulse
module led_tick_prescaler
    import led_pkg::*;
#(
    parameter int TICK_DIV = 25000000
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iCLR,
    input  logic               iEN,
    input  logic [SPEED_W-1:0] iSPEED,
    output logic               oSTEP,
    output logic               oTICK
);

    localparam int          CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [31:0] DIV   = 32'(TICK_DIV);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;
    logic             tick_d;
    logic [31:0]      lim_m1;

    // Count toward the speed-dependent limit; the >= compare makes a speed-up
    // with the count already past the new limit step at once instead of wrapping.
    always_comb begin
        lim_m1 = (DIV >> iSPEED) - 32'd1;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (iCLR) begin
            cnt_d = '0;
        end else if (iEN) begin
            if (32'(cnt_q) >= lim_m1) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter and tick registers
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    // oSTEP is the step decision for the owner's state update; oTICK is its registered copy
    assign oSTEP = tick_d;
    assign oTICK = tick_q;

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - run-time selectable LED pattern generator
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int N_LED      = 4,
    parameter int TICK_DIV   = 25000000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [1:0]         iMODE,
    input  logic [SPEED_W-1:0] iSPEED,
    input  logic               iPAUSE,
    output logic [N_LED-1:0]   oLED,
    output logic               oTICK
);

    localparam logic [N_LED-1:0] PAT_INIT = N_LED'(1);

    logic [1:0]       mode_q;
    logic [1:0]       mode_d;
    logic [N_LED-1:0] pat_q;
    logic [N_LED-1:0] pat_d;
    dir_e             dir_q;
    dir_e             dir_d;
    logic             mode_chg;
    logic             step;
    logic [N_LED-1:0] nxt;

    assign mode_chg = (iMODE != mode_q);

    led_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iCLR   (mode_chg),
        .iEN    (!iPAUSE),
        .iSPEED (iSPEED),
        .oSTEP  (step),
        .oTICK  (oTICK)
    );

    // Next pattern: a mode change reloads and wins over a step; otherwise advance by mode
    always_comb begin
        mode_d = iMODE;
        pat_d  = pat_q;
        dir_d  = dir_q;
        nxt    = pat_q;
        if (mode_chg) begin
            dir_d = DIR_UP;
            pat_d = (iMODE == MODE_BLINK) ? '1 : PAT_INIT;
        end else if (step) begin
            case (mode_q)
                MODE_ROT_L: pat_d = (pat_q << 1) | (pat_q >> (N_LED - 1));
                MODE_ROT_R: pat_d = (pat_q >> 1) | (pat_q << (N_LED - 1));
                MODE_PING: begin
                    if (dir_q == DIR_UP) begin
                        nxt   = pat_q << 1;
                        dir_d = nxt[N_LED-1] ? DIR_DOWN : DIR_UP;
                    end else begin
                        nxt   = pat_q >> 1;
                        dir_d = nxt[0] ? DIR_UP : DIR_DOWN;
                    end
                    // Shifting off either end (only possible with one LED) parks at bit 0
                    if (nxt == '0) begin
                        nxt   = PAT_INIT;
                        dir_d = DIR_UP;
                    end
                    pat_d = nxt;
                end
                default: pat_d = ~pat_q;
            endcase
        end
    end

    // Mode, pattern and direction registers
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            mode_q <= MODE_ROT_L;
            pat_q  <= PAT_INIT;
            dir_q  <= DIR_UP;
        end else begin
            mode_q <= mode_d;
            pat_q  <= pat_d;
            dir_q  <= dir_d;
        end
    end

    // Pin polarity applied straight to the pattern register
    assign oLED = ACTIVE_LOW ? ~pat_q : pat_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - randomized self-checking bench for led_pattern_gen
module tb_led_pattern_gen;

    logic       iCLK = 1'b0;
    logic       iRST;
    logic [1:0] iMODE;
    logic [1:0] iSPEED;
    logic       iPAUSE;

    logic [3:0] led_a;
    logic       tick_a;
    logic [3:0] led_b;
    logic       tick_b;
    logic [0:0] led_c;
    logic       tick_c;

    int n_cmp = 0;
    int n_bad = 0;

    int m_cnt  = 0;
    int m_k    = 0;
    int m_mode = 0;
    int m_tick = 0;

    always #5 iCLK = ~iCLK;

    led_pattern_gen #(.N_LED(4), .TICK_DIV(8), .ACTIVE_LOW(1'b1)) dut (
        .iCLK(iCLK), .iRST(iRST), .iMODE(iMODE), .iSPEED(iSPEED), .iPAUSE(iPAUSE),
        .oLED(led_a), .oTICK(tick_a)
    );

    led_pattern_gen #(.N_LED(4), .TICK_DIV(8), .ACTIVE_LOW(1'b0)) dut_hi (
        .iCLK(iCLK), .iRST(iRST), .iMODE(iMODE), .iSPEED(iSPEED), .iPAUSE(iPAUSE),
        .oLED(led_b), .oTICK(tick_b)
    );

    led_pattern_gen #(.N_LED(1), .TICK_DIV(8), .ACTIVE_LOW(1'b1)) dut_one (
        .iCLK(iCLK), .iRST(iRST), .iMODE(iMODE), .iSPEED(iSPEED), .iPAUSE(iPAUSE),
        .oLED(led_c), .oTICK(tick_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Lit-LED pattern after k steps in a mode, from the position of the lit LED
    function automatic logic [31:0] ref_pat(input int n, input int mode, input int k);
        int          pos;
        int          m;
        logic [31:0] all;
        all = (32'd1 << n) - 32'd1;
        pos = 0;
        case (mode)
            0: pos = k % n;
            1: pos = (n - (k % n)) % n;
            2: begin
                if (n > 1) begin
                    m   = k % (2 * (n - 1));
                    pos = (m < n) ? m : 2 * (n - 1) - m;
                end
            end
            default: return (k % 2 == 0) ? all : 32'd0;
        endcase
        return 32'd1 << pos;
    endfunction

    // Advance the reference by one clock using the inputs presented to that edge
    task automatic model_step();
        int lim;
        if (iRST) begin
            m_cnt = 0; m_k = 0; m_mode = 0; m_tick = 0;
        end else if (int'(iMODE) != m_mode) begin
            m_mode = int'(iMODE); m_cnt = 0; m_k = 0; m_tick = 0;
        end else if (iPAUSE) begin
            m_tick = 0;
        end else begin
            lim = 8 >> iSPEED;
            if (m_cnt >= lim - 1) begin
                m_cnt = 0; m_k++; m_tick = 1;
            end else begin
                m_cnt++; m_tick = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic [31:0] p4;
        logic [31:0] p1;
        p4 = ref_pat(4, m_mode, m_k);
        p1 = ref_pat(1, m_mode, m_k);
        check("led_al1", 32'(led_a), (~p4) & 32'hF);
        check("led_al0", 32'(led_b), p4);
        check("led_n1", 32'(led_c), (~p1) & 32'h1);
        check("tick", 32'(tick_a), 32'(m_tick));
        check("tick_n1", 32'(tick_c), 32'(m_tick));
    endtask

    task automatic cycle();
        model_step();
        @(posedge iCLK);
        #1;
        compare_all();
    endtask

    initial begin
        logic [3:0] held;
        iRST = 1'b1; iMODE = 2'd0; iSPEED = 2'd0; iPAUSE = 1'b0;
        repeat (2) cycle();
        check("reset_led", 32'(led_a), 32'hE);
        check("reset_tick", 32'(tick_a), 32'd0);

        iRST = 1'b0;
        repeat (40) cycle();
        iMODE = 2'd1; repeat (40) cycle();
        iMODE = 2'd2; repeat (60) cycle();
        iMODE = 2'd3; repeat (30) cycle();

        // Speed-up with the count already beyond the new limit
        iMODE = 2'd0; iSPEED = 2'd0;
        for (int i = 0; i < 30 && !(m_cnt == 6 && m_mode == 0); i++) cycle();
        check("reach_cnt6", 32'(m_cnt == 6), 32'd1);
        iSPEED = 2'd3;
        cycle();
        check("speedup_tick", 32'(tick_a), 32'd1);
        repeat (10) cycle();

        // Pause mid-sequence
        iSPEED = 2'd0;
        repeat (13) cycle();
        iPAUSE = 1'b1;
        cycle();
        held = led_a;
        repeat (20) begin
            cycle();
            check("pause_led", 32'(led_a), 32'(held));
            check("pause_tick", 32'(tick_a), 32'd0);
        end
        iPAUSE = 1'b0;
        repeat (20) cycle();

        // Mode change on the edge that would otherwise step
        for (int i = 0; i < 30 && m_cnt != 7; i++) cycle();
        iMODE = 2'd2;
        cycle();
        check("chg_led", 32'(led_a), 32'hE);
        check("chg_tick", 32'(tick_a), 32'd0);

        // Reset while ping-pong travels downward
        for (int i = 0; i < 100 && m_k != 4; i++) cycle();
        check("reach_down", 32'(led_a), 32'hB);
        iRST = 1'b1;
        cycle();
        check("rst_led", 32'(led_a), 32'hE);
        iRST = 1'b0;
        repeat (40) cycle();

        // Randomized run
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) iMODE = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) iSPEED = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) iPAUSE = ~iPAUSE;
            iRST = ($urandom_range(0, 199) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
